// File: rtl/fpmult_radix_iter.sv
// Iterative fixed-point multiplier: c = (a*b) >> d, retiring k multiplier bits per cycle.
// Optional build macro FPMULT_SAT_EN clamps out-of-range results instead of wrapping.
module fpmult_radix_iter #(
   parameter int n     = 32,
   parameter int d     = 16,
   parameter int sign  = 1,
   parameter int k     = 4,
   parameter int round = 0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         recv_val,
   output logic         recv_rdy,
   input  logic [n-1:0] a,
   input  logic [n-1:0] b,
   output logic         send_val,
   input  logic         send_rdy,
   output logic [n-1:0] c
);

   localparam int ITERS = n / k;
   localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;

   typedef logic [2*n-1:0] dword_t;
   typedef logic [n-1:0]   word_t;
   typedef logic [CW-1:0]  cnt_t;
   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   localparam dword_t RND_ONE = dword_t'(1);
   localparam dword_t RND     = (round != 0 && d > 0) ? (RND_ONE << ((d > 0) ? d - 1 : 0)) : '0;
   localparam cnt_t   LAST    = cnt_t'(ITERS - 1);

   if (k < 1 || k > n || (n % k) != 0) begin : g_bad_k
      $error("fpmult_radix_iter: k must satisfy 1 <= k <= n and divide n");
   end
   if (d < 0 || d >= n) begin : g_bad_d
      $error("fpmult_radix_iter: d must satisfy 0 <= d < n");
   end

   state_t state_q, state_d;
   logic   recv_rdy_q, recv_rdy_d;
   logic   send_val_q, send_val_d;
   word_t  c_q, c_d;
   dword_t acc_q, acc_d;
   dword_t a_sh_q, a_sh_d;
   word_t  b_sh_q, b_sh_d;
   cnt_t   cnt_q, cnt_d;

   logic   last_iter;
   dword_t iter_sum;
   dword_t acc_next;
   dword_t p;
   word_t  c_next;

   // a_sh_q holds a_ext already shifted by i*k and b_sh_q the not-yet-retired multiplier bits,
   // so each iteration only looks at a fixed k-bit window.
   always_comb begin
      last_iter = (cnt_q == LAST);
      iter_sum  = '0;
      for (int j = 0; j < k; j++) begin
         if (b_sh_q[j]) begin
            // b[n-1] carries negative weight for two's-complement operands
            if (sign != 0 && last_iter && j == k - 1) begin
               iter_sum = iter_sum - (a_sh_q << j);
            end else begin
               iter_sum = iter_sum + (a_sh_q << j);
            end
         end
      end
      acc_next = acc_q + iter_sum;
      p        = acc_next + RND;
   end

`ifdef FPMULT_SAT_EN
   localparam dword_t SMAX = {{(n+1){1'b0}}, {(n-1){1'b1}}};
   localparam dword_t SMIN = {{(n+1){1'b1}}, {(n-1){1'b0}}};
   localparam dword_t UMAX = {{n{1'b0}}, {n{1'b1}}};
   dword_t q;

   always_comb begin
      if (sign != 0) begin
         q = $unsigned($signed(p) >>> d);
      end else begin
         q = p >> d;
      end
      c_next = word_t'(q);
      if (sign != 0) begin
         if ($signed(q) > $signed(SMAX)) begin
            c_next = {1'b0, {(n-1){1'b1}}};
         end else if ($signed(q) < $signed(SMIN)) begin
            c_next = {1'b1, {(n-1){1'b0}}};
         end
      end else if (q > UMAX) begin
         c_next = {n{1'b1}};
      end
   end
`else
   // Bits [n+d-1:d] of p are the same under logical or arithmetic shift since d < n.
   always_comb begin
      c_next = word_t'(p >> d);
   end
`endif

   always_comb begin
      state_d    = state_q;
      recv_rdy_d = recv_rdy_q;
      send_val_d = send_val_q;
      c_d        = c_q;
      acc_d      = acc_q;
      a_sh_d     = a_sh_q;
      b_sh_d     = b_sh_q;
      cnt_d      = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (recv_val) begin
               a_sh_d     = (sign != 0) ? {{n{a[n-1]}}, a} : {{n{1'b0}}, a};
               b_sh_d     = b;
               acc_d      = '0;
               cnt_d      = '0;
               recv_rdy_d = 1'b0;
               state_d    = S_CALC;
            end
         end
         S_CALC: begin
            acc_d  = acc_next;
            a_sh_d = a_sh_q << k;
            b_sh_d = b_sh_q >> k;
            cnt_d  = cnt_t'(cnt_q + 1'b1);
            if (last_iter) begin
               c_d        = c_next;
               send_val_d = 1'b1;
               state_d    = S_DONE;
            end
         end
         S_DONE: begin
            if (send_rdy) begin
               send_val_d = 1'b0;
               recv_rdy_d = 1'b1;
               state_d    = S_IDLE;
            end
         end
         default: begin
            send_val_d = 1'b0;
            recv_rdy_d = 1'b1;
            state_d    = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         recv_rdy_q <= 1'b1;
         send_val_q <= 1'b0;
         c_q        <= '0;
         acc_q      <= '0;
         a_sh_q     <= '0;
         b_sh_q     <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         recv_rdy_q <= recv_rdy_d;
         send_val_q <= send_val_d;
         c_q        <= c_d;
         acc_q      <= acc_d;
         a_sh_q     <= a_sh_d;
         b_sh_q     <= b_sh_d;
         cnt_q      <= cnt_d;
      end
   end

   assign recv_rdy = recv_rdy_q;
   assign send_val = send_val_q;
   assign c        = c_q;

endmodule

// File: tb/tb_fpmult_radix_iter.sv
// Bench for fpmult_radix_iter: several parameterisations share one stimulus stream and are
// checked against a 64-bit arithmetic model of (a*b) >> 16.
module tb_fpmult_radix_iter;

   localparam int NI = 6;
   localparam int K_TAB [NI] = '{4, 4, 1, 8, 32, 32};
   localparam int S_TAB [NI] = '{1, 1, 1, 0, 1, 0};
   localparam int R_TAB [NI] = '{0, 1, 0, 0, 1, 0};

`ifdef FPMULT_SAT_EN
   localparam logic [31:0] VEC4_EXP = 32'h7FFFFFFF;
`else
   localparam logic [31:0] VEC4_EXP = 32'hFFFE0000;
`endif
   localparam logic [31:0] DIR_A  [5] = '{32'h00018000, 32'hFFFF8000, 32'hFFFFFFFF, 32'h00000001, 32'h7FFF0000};
   localparam logic [31:0] DIR_B  [5] = '{32'h00020000, 32'h00030000, 32'h00008000, 32'h00008000, 32'h00020000};
   localparam logic [31:0] DIR_E0 [5] = '{32'h00030000, 32'hFFFE8000, 32'hFFFFFFFF, 32'h00000000, VEC4_EXP};
   localparam logic [31:0] DIR_E1 [5] = '{32'h00030000, 32'hFFFE8000, 32'h00000000, 32'h00000001, VEC4_EXP};

   logic        clk = 1'b0;
   logic        reset;
   logic        recv_val;
   logic        send_rdy;
   logic [31:0] a;
   logic [31:0] b;
   logic        recv_rdy_v [NI];
   logic        send_val_v [NI];
   logic [31:0] c_v [NI];
   logic [31:0] exp_c [NI];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      fpmult_radix_iter #(
         .n(32), .d(16), .sign(S_TAB[g]), .k(K_TAB[g]), .round(R_TAB[g])
      ) u_dut (
         .clk(clk), .reset(reset), .recv_val(recv_val), .recv_rdy(recv_rdy_v[g]),
         .a(a), .b(b), .send_val(send_val_v[g]), .send_rdy(send_rdy), .c(c_v[g])
      );
   end

   function automatic logic [31:0] ref_mult(input logic [31:0] x, input logic [31:0] y,
                                            input int sg, input int rd);
      longint          sx, sy, sp;
      longint unsigned ux, uy, up;
      if (sg != 0) begin
         sx = longint'($signed(x));
         sy = longint'($signed(y));
         sp = sx * sy + ((rd != 0) ? 64'sd32768 : 64'sd0);
         sp = sp >>> 16;
`ifdef FPMULT_SAT_EN
         if (sp > 64'sd2147483647) return 32'h7FFFFFFF;
         if (sp < -64'sd2147483648) return 32'h80000000;
`endif
         return sp[31:0];
      end
      ux = {32'h0, x};
      uy = {32'h0, y};
      up = ux * uy + ((rd != 0) ? 64'd32768 : 64'd0);
      up = up >> 16;
`ifdef FPMULT_SAT_EN
      if (up > 64'h00000000FFFFFFFF) return 32'hFFFFFFFF;
`endif
      return up[31:0];
   endfunction

   function automatic logic [31:0] pick_operand();
      logic [31:0] v;
      case ($urandom_range(0, 7))
         0: v = 32'h80000000;
         1: v = 32'h7FFFFFFF;
         2: v = 32'h00000000;
         3: v = 32'hFFFFFFFF;
         4: v = $urandom_range(0, 32'h0003FFFF);
         5: v = 32'h0 - $urandom_range(0, 32'h0003FFFF);
         default: v = $urandom;
      endcase
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept one operand pair on all instances, check per-instance latency and result,
   // optionally stall the consumer, then release and check the return to idle.
   task automatic run_op(input logic [31:0] ta, input logic [31:0] tbv, input string name,
                         input int stall);
      bit done [NI];
      int n_done;
      for (int g = 0; g < NI; g++) begin
         exp_c[g] = ref_mult(ta, tbv, S_TAB[g], R_TAB[g]);
         done[g]  = 1'b0;
         checks++;
         if (recv_rdy_v[g] !== 1'b1) begin
            errors++;
            $display("FAIL %s idle_rdy u%0d: got %b want 1", name, g, recv_rdy_v[g]);
         end
      end
      a = ta;
      b = tbv;
      recv_val = 1'b1;
      tick();
      recv_val = 1'b0;
      a = $urandom;
      b = $urandom;
      for (int g = 0; g < NI; g++) begin
         checks++;
         if (recv_rdy_v[g] !== 1'b0 || send_val_v[g] !== 1'b0) begin
            errors++;
            $display("FAIL %s busy u%0d: got rdy=%b val=%b want rdy=0 val=0",
                     name, g, recv_rdy_v[g], send_val_v[g]);
         end
      end
      n_done = 0;
      for (int cyc = 1; cyc <= 40 && n_done < NI; cyc++) begin
         tick();
         for (int g = 0; g < NI; g++) begin
            if (!done[g] && send_val_v[g] === 1'b1) begin
               done[g] = 1'b1;
               n_done++;
               checks++;
               if (cyc != 32 / K_TAB[g]) begin
                  errors++;
                  $display("FAIL %s latency u%0d: got %0d want %0d", name, g, cyc, 32 / K_TAB[g]);
               end
               checks++;
               if (c_v[g] !== exp_c[g]) begin
                  errors++;
                  $display("FAIL %s result u%0d a=%h b=%h: got %h want %h",
                           name, g, ta, tbv, c_v[g], exp_c[g]);
               end
            end
         end
      end
      for (int g = 0; g < NI; g++) begin
         if (!done[g]) begin
            checks++;
            errors++;
            $display("FAIL %s timeout u%0d: got no send_val want one within 40 cycles", name, g);
         end
      end
      for (int s = 0; s < stall; s++) begin
         recv_val = s[0];
         a = $urandom;
         b = $urandom;
         tick();
         for (int g = 0; g < NI; g++) begin
            checks++;
            if (send_val_v[g] !== 1'b1 || recv_rdy_v[g] !== 1'b0 || c_v[g] !== exp_c[g]) begin
               errors++;
               $display("FAIL %s hold u%0d: got val=%b rdy=%b c=%h want val=1 rdy=0 c=%h",
                        name, g, send_val_v[g], recv_rdy_v[g], c_v[g], exp_c[g]);
            end
         end
      end
      recv_val = 1'b0;
      send_rdy = 1'b1;
      tick();
      send_rdy = 1'b0;
      for (int g = 0; g < NI; g++) begin
         checks++;
         if (recv_rdy_v[g] !== 1'b1 || send_val_v[g] !== 1'b0 || c_v[g] !== exp_c[g]) begin
            errors++;
            $display("FAIL %s release u%0d: got rdy=%b val=%b c=%h want rdy=1 val=0 c=%h",
                     name, g, recv_rdy_v[g], send_val_v[g], c_v[g], exp_c[g]);
         end
      end
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      recv_val = 1'b0;
      send_rdy = 1'b0;
      a        = '0;
      b        = '0;
      tick();
      tick();
      for (int g = 0; g < NI; g++) begin
         checks++;
         if (recv_rdy_v[g] !== 1'b1 || send_val_v[g] !== 1'b0 || c_v[g] !== 32'h0) begin
            errors++;
            $display("FAIL reset u%0d: got rdy=%b val=%b c=%h want rdy=1 val=0 c=0",
                     g, recv_rdy_v[g], send_val_v[g], c_v[g]);
         end
      end
      reset = 1'b0;
   endtask

   task automatic test_directed();
      for (int i = 0; i < 5; i++) begin
         run_op(DIR_A[i], DIR_B[i], "directed", 0);
         checks++;
         if (c_v[0] !== DIR_E0[i]) begin
            errors++;
            $display("FAIL directed_trunc vec%0d: got %h want %h", i, c_v[0], DIR_E0[i]);
         end
         checks++;
         if (c_v[1] !== DIR_E1[i]) begin
            errors++;
            $display("FAIL directed_round vec%0d: got %h want %h", i, c_v[1], DIR_E1[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      run_op(32'h00018000, 32'h00020000, "backpressure", 5);
      run_op($urandom, $urandom, "backpressure_rand", 7);
   endtask

   task automatic test_abort();
      a = $urandom;
      b = $urandom;
      recv_val = 1'b1;
      tick();
      recv_val = 1'b0;
      tick();
      tick();
      tick();
      reset = 1'b1;
      tick();
      for (int g = 0; g < NI; g++) begin
         checks++;
         if (recv_rdy_v[g] !== 1'b1 || send_val_v[g] !== 1'b0 || c_v[g] !== 32'h0) begin
            errors++;
            $display("FAIL abort u%0d: got rdy=%b val=%b c=%h want rdy=1 val=0 c=0",
                     g, recv_rdy_v[g], send_val_v[g], c_v[g]);
         end
      end
      reset = 1'b0;
      run_op(32'hFFFF8000, 32'h00030000, "after_abort", 0);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         run_op($urandom, $urandom, "back_to_back", 0);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 24; i++) begin
         run_op(pick_operand(), pick_operand(), "random", $urandom_range(0, 2));
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_abort();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
